conv_encoder_frame: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder that turns an 8-bit message into the 16-bit codeword consumed by the decoder path (PISO → Viterbi decoder → SIPO). It is the transmit-side counterpart of the Viterbi decoding chain, so on-chip frames can be encoded and looped back through the decoder. It emits the coded symbols serially, 2 bits per cycle, for direct feed into the decoder's 2-bit symbol input. It also packs them into one 16-bit word for the PISO input.

---
 rtl/conv_encoder_frame_if.sv | 24 ++
 rtl/conv_encoder_frame.sv | 94 +++++++++
 tb/tb_conv_encoder_frame.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_encoder_frame_if.sv
// Frame request / coded-symbol bundle for conv_encoder_frame.
// The encoder is the slave; a frame source and symbol sink form the master.
interface conv_encoder_frame_if #(
    parameter int unsigned SIZE_MSG  = 8,
    parameter int unsigned SIZE_CODE = 16
);
    logic                 i_start;
    logic [SIZE_MSG-1:0]  i_data;
    logic                 o_busy;
    logic [1:0]           o_sym;
    logic                 o_sym_valid;
    logic [SIZE_CODE-1:0] o_code;
    logic                 o_done;

    modport master (
        output i_start, i_data,
        input  o_busy, o_sym, o_sym_valid, o_code, o_done
    );

    modport slave (
        input  i_start, i_data,
        output o_busy, o_sym, o_sym_valid, o_code, o_done
    );
endinterface

// File: rtl/conv_encoder_frame.sv
// Rate-1/2, K=3 convolutional encoder: one message frame in, serial symbols plus packed codeword out.
// Define CONV_ENC_STATE_HOLD_EN to carry the encoder state {s1,s0} across frames (stream mode).
module conv_encoder_frame #(
    parameter int unsigned SIZE_MSG  = 8,
    parameter int unsigned SIZE_CODE = 16,
    parameter logic [2:0]  G0        = 3'b111,
    parameter logic [2:0]  G1        = 3'b101
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    conv_encoder_frame_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(SIZE_MSG + 1);

    typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;

    state_t               state_q, state_d;
    logic [SIZE_MSG-1:0]  msg_q, msg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           enc_q, enc_d;
    logic [1:0]           sym_q, sym_d;
    logic                 sym_valid_q, sym_valid_d;
    logic [SIZE_CODE-1:0] code_q, code_d;
    logic [2:0]           window;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            msg_q       <= '0;
            cnt_q       <= '0;
            enc_q       <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            code_q      <= '0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            cnt_q       <= cnt_d;
            enc_q       <= enc_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            code_q      <= code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        cnt_d       = cnt_q;
        enc_d       = enc_q;
        sym_d       = '0;
        sym_valid_d = 1'b0;
        code_d      = code_q;
        window      = {msg_q[SIZE_MSG-1], enc_q};

        case (state_q)
            // DONE also samples i_start so back-to-back frames keep the 10-cycle spacing.
            IDLE, DONE: begin
                if (bus.i_start) begin
                    state_d = ENCODE;
                    msg_d   = bus.i_data;
                    cnt_d   = '0;
                    code_d  = '0;
`ifdef CONV_ENC_STATE_HOLD_EN
                    enc_d   = enc_q;
`else
                    enc_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ENCODE: begin
                if (cnt_q == CNT_W'(SIZE_MSG)) begin
                    state_d = DONE;
                end else begin
                    sym_d       = {^(window & G0), ^(window & G1)};
                    sym_valid_d = 1'b1;
                    enc_d       = window[2:1];
                    msg_d       = msg_q << 1;
                    code_d      = {code_q[SIZE_CODE-3:0], sym_d};
                    cnt_d       = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_done      = (state_q == DONE);
    assign bus.o_sym       = sym_q;
    assign bus.o_sym_valid = sym_valid_q;
    assign bus.o_code      = code_q;
endmodule

// File: tb/tb_conv_encoder_frame.sv
// Directed self-checking bench for conv_encoder_frame with hand-computed codewords.
module tb_conv_encoder_frame;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    conv_encoder_frame_if #(.SIZE_MSG(8), .SIZE_CODE(16)) bus ();

    conv_encoder_frame #(
        .SIZE_MSG (8),
        .SIZE_CODE(16),
        .G0       (3'b111),
        .G1       (3'b101)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.i_start = 1'b0;
        bus.i_data  = '0;
        rst_n       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Hard-decision decode of an error-free codeword from state 00: b = g1 ^ s0.
    function automatic logic [7:0] decode(input logic [15:0] c);
        logic       s0, s1, b;
        logic [1:0] s;
        logic [7:0] out;
        s0 = 1'b0; s1 = 1'b0; out = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            s   = c[15 - 2*i -: 2];
            b   = s[0] ^ s0;
            s0  = s1;
            s1  = b;
            out = {out[6:0], b};
        end
        return out;
    endfunction

    // Starts a frame at T0 and observes edges T1..T10.
    task automatic run_frame(input logic [7:0] data, output logic [15:0] syms,
                             output logic [15:0] code, output int vcnt,
                             output bit timing_ok, output bit idle_zero);
        syms = '0; code = '0; vcnt = 0; timing_ok = 1'b1; idle_zero = 1'b1;
        bus.i_data  = data;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.o_sym_valid) begin
                vcnt++;
                syms = {syms[13:0], bus.o_sym};
            end else if (bus.o_sym !== 2'b00) begin
                idle_zero = 1'b0;
            end
            if (bus.o_sym_valid !== (k <= 8)) timing_ok = 1'b0;
            if (bus.o_done !== (k == 9)) timing_ok = 1'b0;
            if (bus.o_busy !== (k <= 9)) timing_ok = 1'b0;
            if (k == 9) code = bus.o_code;
        end
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0;
        bus.i_data  = '0;
        rst_n       = 1'b0;
        #3;
        checks++;
        if ({bus.o_busy, bus.o_sym, bus.o_sym_valid, bus.o_done, bus.o_code} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b sym=%b vld=%b done=%b code=%h expected all 0",
                     bus.o_busy, bus.o_sym, bus.o_sym_valid, bus.o_done, bus.o_code);
        end
        do_reset();
    endtask

    task automatic test_frame_b0();
        logic [15:0] syms, code;
        int vcnt;
        bit tok, iz;
        do_reset();
        run_frame(8'hB0, syms, code, vcnt, tok, iz);
        checks++;
        if (syms !== 16'hE170) begin
            failures++;
            $display("FAIL b0_sym_seq got %h expected e170", syms);
        end
        checks++;
        if (code !== 16'hE170) begin
            failures++;
            $display("FAIL b0_code got %h expected e170", code);
        end
        checks++;
        if (vcnt !== 8) begin
            failures++;
            $display("FAIL b0_valid_count got %0d expected 8", vcnt);
        end
        checks++;
        if (tok !== 1'b1) begin
            failures++;
            $display("FAIL b0_timing got %b expected 1", tok);
        end
        checks++;
        if (iz !== 1'b1) begin
            failures++;
            $display("FAIL b0_sym_zero_when_invalid got %b expected 1", iz);
        end
        checks++;
        if (bus.o_code !== 16'hE170) begin
            failures++;
            $display("FAIL b0_code_held got %h expected e170", bus.o_code);
        end
    endtask

    task automatic test_frame_ff_then_00();
        logic [15:0] syms, code, exp2;
        int vcnt;
        bit tok, iz;
        do_reset();
        run_frame(8'hFF, syms, code, vcnt, tok, iz);
        checks++;
        if (code !== 16'hDAAA) begin
            failures++;
            $display("FAIL ff_code got %h expected daaa", code);
        end
        run_frame(8'h00, syms, code, vcnt, tok, iz);
`ifdef CONV_ENC_STATE_HOLD_EN
        exp2 = 16'h7000;
`else
        exp2 = 16'h0000;
`endif
        checks++;
        if (code !== exp2) begin
            failures++;
            $display("FAIL zero_after_ff_code got %h expected %h", code, exp2);
        end
        checks++;
        if (syms !== exp2) begin
            failures++;
            $display("FAIL zero_after_ff_syms got %h expected %h", syms, exp2);
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] code9;
        do_reset();
        bus.i_data  = 8'hB0;
        bus.i_start = 1'b1;
        tick();                                   // T0
        bus.i_start = 1'b0;
        code9 = '0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3 || k == 9) begin
                bus.i_start = 1'b1;
                bus.i_data  = 8'h12;
            end else if (k == 10) begin
                bus.i_start = 1'b1;
                bus.i_data  = 8'hFF;
            end else begin
                bus.i_start = 1'b0;
            end
            tick();                               // Tk
            if (k == 9) code9 = bus.o_code;
        end
        bus.i_start = 1'b0;
        checks++;
        if (code9 !== 16'hE170) begin
            failures++;
            $display("FAIL ignore_start_code got %h expected e170", code9);
        end
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_code !== 16'h0000) begin
            failures++;
            $display("FAIL start_at_t10_accept got busy=%b code=%h expected busy=1 code=0000",
                     bus.o_busy, bus.o_code);
        end
        for (int k = 11; k <= 19; k++) tick();
        checks++;
        if (bus.o_done !== 1'b1 || bus.o_code !== 16'hDAAA) begin
            failures++;
            $display("FAIL back_to_back_code got done=%b code=%h expected done=1 code=daaa",
                     bus.o_done, bus.o_code);
        end
        tick();
        checks++;
        if (bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_idle got busy=%b expected 0", bus.o_busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] syms, code;
        int vcnt;
        bit tok, iz;
        do_reset();
        bus.i_data  = 8'hB0;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_busy, bus.o_sym, bus.o_sym_valid, bus.o_done, bus.o_code} !== 21'd0) begin
            failures++;
            $display("FAIL midframe_reset got busy=%b sym=%b vld=%b done=%b code=%h expected all 0",
                     bus.o_busy, bus.o_sym, bus.o_sym_valid, bus.o_done, bus.o_code);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_frame(8'hB0, syms, code, vcnt, tok, iz);
        checks++;
        if (code !== 16'hE170 || tok !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_code got code=%h timing=%b expected code=e170 timing=1", code, tok);
        end
    endtask

    task automatic test_loopback();
        logic [7:0]  msgs [3];
        logic [15:0] syms, code;
        logic [7:0]  rec;
        int vcnt;
        bit tok, iz;
        msgs[0] = 8'hB0; msgs[1] = 8'h5A; msgs[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            run_frame(msgs[i], syms, code, vcnt, tok, iz);
            rec = decode(code);
            checks++;
            if (rec !== msgs[i]) begin
                failures++;
                $display("FAIL loopback_%0d got %h expected %h (code %h)", i, rec, msgs[i], code);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.i_start = 1'b0;
        bus.i_data  = '0;
        test_reset();
        test_frame_b0();
        test_frame_ff_then_00();
        test_start_ignored();
        test_reset_mid_frame();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
